// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-clock frame, device ACK.
// The PS2Clk/PS2Data pins are driven open-drain through pull-low enables.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int REQ_CYCLES     = 200,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_low,
  output logic       ps2_data_low
);

  localparam int PH_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int PW     = $clog2(PH_MAX + 1);
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW     = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SHIFT,
    S_WAIT_IDLE
  } state_t;

  // Returns {new_level, new_count}; the level only follows the sample after
  // FILTER_LEN consecutive disagreeing samples.
  function automatic logic [FW:0] filt_step(input logic smp, input logic cur,
                                            input logic [FW-1:0] cnt);
    if (smp == cur)
      filt_step = {cur, {FW{1'b0}}};
    else if (cnt == FW'(FILTER_LEN - 1))
      filt_step = {smp, {FW{1'b0}}};
    else
      filt_step = {cur, cnt + 1'b1};
  endfunction

  logic          clk_p0, clk_p1, data_p0, data_p1;
  logic          clk_filt, data_filt, clk_fall;
  logic [FW-1:0] clk_fcnt, data_fcnt;
  logic [FW:0]   clk_step, data_step;

  state_t        state, state_n;
  logic [PW-1:0] ph_cnt, ph_cnt_n;
  logic [TW-1:0] tmo_cnt, tmo_cnt_n;
  logic [3:0]    bit_k, bit_k_n;
  logic          drive_q, drive_n;
  logic          ack_q, ack_n;
  logic          done_q, done_n, err_q, err_n;
  logic          accept, tmo_hit;
  logic [7:0]    data_q;
  logic          par_q;

  assign clk_step  = filt_step(clk_p1, clk_filt, clk_fcnt);
  assign data_step = filt_step(data_p1, data_filt, data_fcnt);

  // Stage p0/p1: two-flop synchronizers, then glitch filters and fall detect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_p0    <= 1'b1;
      clk_p1    <= 1'b1;
      data_p0   <= 1'b1;
      data_p1   <= 1'b1;
      clk_filt  <= 1'b1;
      data_filt <= 1'b1;
      clk_fcnt  <= '0;
      data_fcnt <= '0;
      clk_fall  <= 1'b0;
    end else begin
      clk_p0    <= ps2_clk_in;
      clk_p1    <= clk_p0;
      data_p0   <= ps2_data_in;
      data_p1   <= data_p0;
      {clk_filt, clk_fcnt}   <= clk_step;
      {data_filt, data_fcnt} <= data_step;
      clk_fall  <= clk_filt & ~clk_step[FW];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      ph_cnt  <= '0;
      tmo_cnt <= '0;
      bit_k   <= '0;
      drive_q <= 1'b0;
      ack_q   <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      ph_cnt  <= ph_cnt_n;
      tmo_cnt <= tmo_cnt_n;
      bit_k   <= bit_k_n;
      drive_q <= drive_n;
      ack_q   <= ack_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      data_q <= tx_data;
      par_q  <= ~^tx_data;
    end
  end

  assign tmo_hit = (state == S_SHIFT) && (tmo_cnt == TW'(TIMEOUT_CYCLES));

  always_comb begin
    state_n   = state;
    ph_cnt_n  = ph_cnt;
    tmo_cnt_n = tmo_cnt;
    bit_k_n   = bit_k;
    drive_n   = drive_q;
    ack_n     = ack_q;
    done_n    = 1'b0;
    err_n     = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (tx_valid) begin
          accept   = 1'b1;
          ph_cnt_n = '0;
          state_n  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (ph_cnt == PW'(INHIBIT_CYCLES - 1)) begin
          ph_cnt_n = '0;
          state_n  = S_REQ;
        end else begin
          ph_cnt_n = ph_cnt + 1'b1;
        end
      end
      S_REQ: begin
        if (ph_cnt == PW'(REQ_CYCLES - 1)) begin
          tmo_cnt_n = '0;
          bit_k_n   = '0;
          drive_n   = 1'b1;
          state_n   = S_SHIFT;
        end else begin
          ph_cnt_n = ph_cnt + 1'b1;
        end
      end
      S_SHIFT: begin
        if (tmo_hit) begin
          drive_n = 1'b0;
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          tmo_cnt_n = tmo_cnt + 1'b1;
          if (clk_fall) begin
            bit_k_n = bit_k + 4'd1;
            if (bit_k < 4'd8) begin
              drive_n = ~data_q[bit_k[2:0]];
            end else if (bit_k == 4'd8) begin
              drive_n = ~par_q;
            end else if (bit_k == 4'd9) begin
              drive_n = 1'b0;
            end else begin
              // Eleventh edge: the device holds data low here to acknowledge
              ack_n   = data_filt;
              drive_n = 1'b0;
              state_n = S_WAIT_IDLE;
            end
          end
        end
      end
      S_WAIT_IDLE: begin
        if (clk_filt && data_filt) begin
          done_n  = ~ack_q;
          err_n   = ack_q;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign tx_ready     = (state == S_IDLE);
  assign busy         = (state != S_IDLE);
  assign tx_done      = done_q;
  assign tx_error     = err_q;
  assign ps2_clk_low  = (state == S_INHIBIT) || (state == S_REQ);
  assign ps2_data_low = (state == S_REQ) || ((state == S_SHIFT) && drive_q && !tmo_hit);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on open-drain lines.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 100;
  localparam int REQ = 20;
  localparam int TMO = 3000;
  localparam int HP  = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, tx_done, tx_error, ps2_clk_low, ps2_data_low;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       clk_line, data_line;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  assign clk_line  = dev_clk & ~ps2_clk_low;
  assign data_line = dev_data & ~ps2_data_low;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES(REQ),
    .FILTER_LEN(8),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .tx_done(tx_done),
    .tx_error(tx_error),
    .ps2_clk_in(clk_line),
    .ps2_data_in(data_line),
    .ps2_clk_low(ps2_clk_low),
    .ps2_data_low(ps2_data_low)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if (tx_done && tx_error) both_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tx_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Device: waits for the request, clocks 11 edges, samples data on each rise.
  task automatic dev_frame(input bit ack, input bit glitch, input int abort_e,
                           output logic [9:0] bits, output bit ok);
    bits = '0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      if (clk_line && !data_line) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    for (int e = 1; e <= 11; e++) begin
      if (glitch && e == 5) begin
        repeat (15) @(posedge clk);
        dev_clk = 1'b0;
        repeat (3) @(posedge clk);
        dev_clk = 1'b1;
        repeat (HP - 18) @(posedge clk);
      end else begin
        repeat (HP - 5) @(posedge clk);
        if (e == 11 && ack) dev_data = 1'b0;
        repeat (5) @(posedge clk);
      end
      dev_clk = 1'b0;
      if (e == abort_e) begin
        repeat (20) @(posedge clk);
        return;
      end
      repeat (HP) @(posedge clk);
      dev_clk = 1'b1;
      if (e <= 10) bits[e-1] = data_line;
    end
    repeat (5) @(posedge clk);
    dev_data = 1'b1;
    repeat (HP) @(posedge clk);
  endtask

  task automatic full_frame(input string tag, input logic [7:0] d, input bit ack,
                            input bit glitch, input logic [9:0] exp_bits);
    logic [9:0] bits;
    bit ok;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send(d);
    dev_frame(ack, glitch, 0, bits, ok);
    repeat (5) @(negedge clk);
    check({tag, "_req_seen"}, 32'(ok), 32'd1);
    check({tag, "_bits"}, 32'(bits), 32'(exp_bits));
    check({tag, "_done"}, 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
    check({tag, "_err"}, 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
    check({tag, "_idle"}, {29'd0, busy, ps2_clk_low, ps2_data_low}, 32'd0);
  endtask

  initial begin
    logic [9:0] bits0, bits1;
    bit ok0, ok1, okd;
    int ci, cd, n, d0, e0;

    #1;
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_outs", {27'd0, busy, tx_done, tx_error, ps2_clk_low, ps2_data_low}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // 0xED with ACK, measuring inhibit and request durations
    d0 = done_cnt;
    send(8'hED);
    fork
      dev_frame(1'b1, 1'b0, 0, bits0, ok0);
      begin
        ci = 0;
        cd = 0;
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          if (!(ps2_clk_low && !ps2_data_low)) break;
          ci++;
        end
        while (ps2_clk_low && ps2_data_low && cd < 1000) begin
          cd++;
          @(negedge clk);
        end
        check("ed_inhibit_len", 32'(ci), 32'(INH));
        check("ed_req_len", 32'(cd), 32'(REQ));
        check("ed_start_low", 32'(ps2_data_low), 32'd1);
      end
    join
    repeat (5) @(negedge clk);
    check("ed_req_seen", 32'(ok0), 32'd1);
    check("ed_bits", 32'(bits0), 32'h3ED);
    check("ed_done", 32'(done_cnt - d0), 32'd1);
    check("ed_ready", {30'd0, tx_ready, busy}, 32'd2);

    // Back-to-back 0x00 then 0x01
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h00);
    fork
      dev_frame(1'b1, 1'b0, 0, bits0, ok0);
      begin
        wait_done(okd);
        check("b2b_first_done", 32'(okd), 32'd1);
        check("b2b_ready_at_pulse", 32'(tx_ready), 32'd1);
        tx_data  = 8'h01;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        check("b2b_second_accept", {30'd0, busy, ps2_clk_low}, 32'd3);
      end
    join
    dev_frame(1'b1, 1'b0, 0, bits1, ok1);
    repeat (5) @(negedge clk);
    check("b2b_bits0", 32'(bits0), 32'h300);
    check("b2b_bits1", 32'(bits1), 32'h201);
    check("b2b_done", 32'(done_cnt - d0), 32'd2);
    check("b2b_err", 32'(err_cnt - e0), 32'd0);

    full_frame("noack", 8'hA5, 1'b0, 1'b0, 10'h3A5);

    // Device never clocks
    e0 = err_cnt;
    send(8'h3C);
    for (int i = 0; i < 300 && ps2_clk_low; i++) @(negedge clk);
    check("tmo_start_low", {30'd0, ps2_clk_low, ps2_data_low}, 32'd1);
    n = 0;
    while (ps2_data_low && n < TMO + 100) begin
      @(negedge clk);
      n++;
    end
    check("tmo_len", 32'(n), 32'(TMO));
    check("tmo_release", {29'd0, ps2_clk_low, ps2_data_low, tx_error}, 32'd0);
    @(negedge clk);
    check("tmo_err_pulse", {30'd0, tx_error, tx_ready}, 32'd3);
    @(negedge clk);
    check("tmo_err_count", 32'(err_cnt - e0), 32'd1);

    // Asynchronous reset mid-frame after edge 4
    send(8'h55);
    dev_frame(1'b1, 1'b0, 4, bits0, ok0);
    #2;
    check("mid_data_low", 32'(ps2_data_low), 32'd1);
    d0 = done_cnt;
    e0 = err_cnt;
    rst = 1'b0;
    #1;
    check("mid_rst_release", {30'd0, ps2_clk_low, ps2_data_low}, 32'd0);
    check("mid_rst_idle", {30'd0, tx_ready, busy}, 32'd2);
    dev_clk = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("mid_no_pulse", 32'(done_cnt - d0 + err_cnt - e0), 32'd0);
    full_frame("ff", 8'hFF, 1'b1, 1'b0, 10'h3FF);

    full_frame("glitch", 8'hC3, 1'b1, 1'b1, 10'h3C3);

    check("never_both", 32'(both_cnt), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte to the keyboard, e.g. 0xED for set-LEDs or 0xFF for reset.
- Sits beside the PS/2 receiver on the same PS2Clk/PS2Data lines and drives them through open-drain pull-low enables.
- Runs the full request-to-send, 11-clock serial frame and device-ACK sequence; reports completion or error to the command logic.
- Keyboard response bytes (e.g. 0xFA) are handled by the existing receive path, not by this block.

Parameters:
- INHIBIT_CYCLES, 10000, clk cycles PS2Clk is held low before the request (100 us at 100 MHz).
- REQ_CYCLES, 200, clk cycles with PS2Data low and PS2Clk still low before PS2Clk is released.
- FILTER_LEN, 8, consecutive equal synchronized samples required before a filtered line level changes.
- TIMEOUT_CYCLES, 2000000, maximum clk cycles from PS2Clk release to ACK sample (20 ms).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- tx_data  input  8  command byte
- tx_valid  input  1  request to send tx_data
- tx_ready  output  1  high only in IDLE; byte accepted when tx_valid && tx_ready
- busy  output  1  high in every state except IDLE
- tx_done  output  1  one-cycle pulse: frame sent and ACK received
- tx_error  output  1  one-cycle pulse: ACK missing or timeout
- ps2_clk_in  input  1  raw PS2Clk pin level
- ps2_data_in  input  1  raw PS2Data pin level
- ps2_clk_low  output  1  1 = pull PS2Clk low, 0 = release
- ps2_data_low  output  1  1 = pull PS2Data low, 0 = release

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. tx_ready=1; busy, tx_done, tx_error, ps2_clk_low and ps2_data_low all 0. Both lines are released immediately, including mid-frame. Filter outputs reset to 1.
- Input conditioning: each pin passes a 2-FF synchronizer, then a FILTER_LEN glitch filter. A falling edge is filtered 1→0 on the clock line; it is flagged 2+FILTER_LEN cycles after the pin edge.
- Accept: in IDLE, tx_valid && tx_ready latches tx_data and computes parity = ~^tx_data (odd parity). Next state INHIBIT. tx_valid is ignored outside IDLE.
- INHIBIT: ps2_clk_low=1 for exactly INHIBIT_CYCLES cycles, then REQ.
- REQ: ps2_clk_low=1 and ps2_data_low=1 for REQ_CYCLES cycles, then SHIFT. ps2_clk_low drops to 0 on entry to SHIFT; the start bit (0) stays driven and the timeout counter starts.
- SHIFT: edge counter k increments on each filtered falling edge of PS2Clk. On the cycle after edge k:
  - k=1..8: ps2_data_low = ~data[k-1] (LSB first).
  - k=9: ps2_data_low = ~parity.
  - k=10: ps2_data_low = 0 (stop bit, line released).
  - k=11: sample the filtered data line; 0 = ACK. Go to WAIT_IDLE.
- WAIT_IDLE: wait until both filtered lines are 1. Then pulse tx_done if ACK was 0, else pulse tx_error. Return to IDLE.
- Timeout: if the counter reaches TIMEOUT_CYCLES before the k=11 sample, release both lines the same cycle, pulse tx_error, return to IDLE. The pulse follows the timeout by 1 cycle.
- tx_done and tx_error are never high together. tx_ready rises in the same cycle as the pulse.
- Back-to-back: a new accept is possible in the cycle after a done or error pulse.
- Filtered clock edges arriving in IDLE, INHIBIT or REQ are ignored.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and ACKing → PS2Clk low for 10000 cycles; data low on release; device samples 0,1,0,1,1,0,1,1,1,1(parity),1(stop); ACK seen; tx_done pulses once; busy→0.
- Send 0x00 then 0x01 back-to-back → parity bits 1 and 0; second accept occurs the cycle after the first tx_done; two tx_done pulses, no tx_error.
- Device model does not ACK (data high at edge 11) → tx_error pulses once; tx_done stays 0; lines released.
- Device never clocks after request → after exactly TIMEOUT_CYCLES, ps2_clk_low=ps2_data_low=0, tx_error pulses, tx_ready=1.
- Assert rst=0 mid-frame after edge 4 → both drive outputs drop to 0 asynchronously; after release, state IDLE with no pulses; a subsequent 0xFF send completes normally.
- Inject a 3-cycle glitch low on PS2Clk during SHIFT → no edge counted; transmitted frame bit-exact.
